// File: rtl/mor1kx_shadow_stack_chk.sv
// mor1kx_shadow_stack_chk: return-address shadow stack checker.
// Every link-register write pushes a return address. Every accepted return
// pops the top entry and compares it with the actual jump target. A mismatch
// raises a sticky violation and captures the offending target.
// Optional feature macro: SHADOW_STACK_HALT_EN. When defined, halt follows
// violation, so no further returns are accepted until clear.
module mor1kx_shadow_stack_chk #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lr_we,
    input  logic [DATA_WIDTH-1:0] lr_din,
    input  logic                  ret_valid,
    input  logic [DATA_WIDTH-1:0] ret_target,
    output logic                  ret_ready,
    output logic                  ret_done,
    output logic                  ret_ok,
    output logic                  violation,
    output logic [DATA_WIDTH-1:0] viol_addr,
    output logic                  overflow,
    output logic                  underflow,
    output logic [DEPTH_LOG2:0]   depth,
    input  logic                  clear,
    output logic                  halt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] ZERO_C  = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0] ONE_C   = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [DEPTH_LOG2:0]     depth_r;
    logic [DEPTH_LOG2:0]     depth_pop_s;
    logic [DEPTH_LOG2:0]     depth_nxt_s;
    logic [DATA_WIDTH-1:0]   target_r;
    logic [DATA_WIDTH-1:0]   rd_data_r;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
    logic                    ret_done_r;
    logic                    ret_ok_r;
    logic                    violation_r;
    logic [DATA_WIDTH-1:0]   viol_addr_r;
    logic                    overflow_r;
    logic                    underflow_r;
    logic                    halt_s;
    logic                    ret_ready_s;
    logic                    accept_s;
    logic                    pop_s;
    logic                    under_s;
    logic                    push_ok_s;
    logic                    over_s;
    logic                    check_s;
    logic                    mismatch_s;

`ifdef SHADOW_STACK_HALT_EN
    assign halt_s = violation_r;
`else
    assign halt_s = 1'b0;
`endif

    assign ret_ready_s = (state_r == ST_IDLE) && !halt_s;

    // Pop-then-push arithmetic, the FSM next state and the compare result.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = ret_valid && ret_ready_s;
        pop_s       = accept_s && (depth_r != ZERO_C);
        under_s     = accept_s && (depth_r == ZERO_C);
        depth_pop_s = depth_r;
        if (pop_s) begin
            depth_pop_s = depth_r - ONE_C;
        end else begin
            depth_pop_s = depth_r;
        end
        push_ok_s   = lr_we && (depth_pop_s != DEPTH_C);
        over_s      = lr_we && (depth_pop_s == DEPTH_C);
        depth_nxt_s = depth_pop_s;
        if (push_ok_s) begin
            depth_nxt_s = depth_pop_s + ONE_C;
        end else begin
            depth_nxt_s = depth_pop_s;
        end
        check_s     = (state_r == ST_CHECK);
        mismatch_s  = check_s && (rd_data_r != target_r);
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CHECK: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Stack RAM: a pop reads the top slot and a push writes the slot above the
    // popped depth. Both use the same index in the pop+push case, and the read
    // then returns the old data.
    always_ff @(posedge clk) begin
        if (pop_s) begin
            rd_data_r <= mem_r[depth_pop_s[DEPTH_LOG2-1:0]];
        end
        if (push_ok_s) begin
            mem_r[depth_pop_s[DEPTH_LOG2-1:0]] <= lr_din;
        end
    end

    // State, depth, latched target, completion pulse and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            depth_r     <= ZERO_C;
            target_r    <= {DATA_WIDTH{1'b0}};
            ret_done_r  <= 1'b0;
            ret_ok_r    <= 1'b0;
            violation_r <= 1'b0;
            viol_addr_r <= {DATA_WIDTH{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            depth_r    <= depth_nxt_s;
            ret_done_r <= under_s || check_s;
            ret_ok_r   <= check_s && !mismatch_s;
            if (pop_s) begin
                target_r <= ret_target;
            end
            if (clear) begin
                violation_r <= 1'b0;
                overflow_r  <= 1'b0;
                underflow_r <= 1'b0;
            end else begin
                // The first mismatch owns viol_addr until the next clear.
                if (mismatch_s && !violation_r) begin
                    violation_r <= 1'b1;
                    viol_addr_r <= target_r;
                end
                if (over_s) begin
                    overflow_r <= 1'b1;
                end
                if (under_s) begin
                    underflow_r <= 1'b1;
                end
            end
        end
    end

    assign ret_ready = ret_ready_s;
    assign ret_done  = ret_done_r;
    assign ret_ok    = ret_ok_r;
    assign violation = violation_r;
    assign viol_addr = viol_addr_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;
    assign depth     = depth_r;
    assign halt      = halt_s;

endmodule
